// File: rtl/bp_resolve_ctrl.sv
// Branch-resolution scheduler: queues fetch-time predictions in order, issues one
// predictor table update per resolved branch and repairs global history on a mispredict.
module bp_resolve_ctrl #(
  parameter int ADDR_W = 64,
  parameter int GHR_W  = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lookup_valid,
  output logic                       lookup_ready,
  input  logic [ADDR_W-1:0]          lookup_addr,
  input  logic                       pred_taken,
  input  logic [GHR_W-1:0]           pred_ghr,
  input  logic                       resolve_valid,
  output logic                       resolve_ready,
  input  logic                       resolve_taken,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [ADDR_W-1:0]          upd_addr,
  output logic [GHR_W-1:0]           upd_ghr,
  output logic                       upd_taken,
  output logic                       upd_mispredict,
  output logic                       ghr_restore_valid,
  output logic [GHR_W-1:0]           ghr_restore_value,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           hit_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   L_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] L_ACC_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, UPDATE, RECOVER} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [ADDR_W-1:0]  r_addrMem [DEPTH];
  logic               r_predMem [DEPTH];
  logic [GHR_W-1:0]   r_ghrMem  [DEPTH];

  logic [ADDR_W-1:0]  r_updAddr;
  logic [GHR_W-1:0]   r_updGhr;
  logic               r_updTaken;
  logic               r_updMispredict;
  logic               r_ghrRestoreValid;
  logic [GHR_W-1:0]   r_ghrRestoreValue;
  logic [CNT_W-1:0]   r_totalCount;
  logic [CNT_W-1:0]   r_hitCount;

  logic w_push;
  logic w_pop;
  logic w_resolveAccept;

  // Nothing younger than a known mispredict may enter the queue.
  assign lookup_ready    = (r_count < L_DEPTH) && (r_state != RECOVER) &&
                           !((r_state == UPDATE) && r_updMispredict);
  assign resolve_ready   = (r_state == IDLE) && (r_count != '0);
  assign w_push          = lookup_valid && lookup_ready;
  assign w_pop           = (r_state == UPDATE) && upd_ready;
  assign w_resolveAccept = resolve_valid && resolve_ready;

  assign upd_valid         = (r_state == UPDATE);
  assign upd_addr          = r_updAddr;
  assign upd_ghr           = r_updGhr;
  assign upd_taken         = r_updTaken;
  assign upd_mispredict    = r_updMispredict;
  assign ghr_restore_valid = r_ghrRestoreValid;
  assign ghr_restore_value = r_ghrRestoreValue;
  assign occupancy         = r_count;
  assign total_count       = r_totalCount;
  assign hit_count         = r_hitCount;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addrMem[r_tail] <= lookup_addr;
      r_predMem[r_tail] <= pred_taken;
      r_ghrMem[r_tail]  <= pred_ghr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_updAddr         <= '0;
      r_updGhr          <= '0;
      r_updTaken        <= 1'b0;
      r_updMispredict   <= 1'b0;
      r_ghrRestoreValid <= 1'b0;
      r_ghrRestoreValue <= '0;
      r_totalCount      <= '0;
      r_hitCount        <= '0;
    end else begin
      r_ghrRestoreValid <= 1'b0;
      if (w_push) r_tail <= r_tail + L_PTR_ONE;

      if (r_state == RECOVER) begin
        r_count <= '0;
      end else begin
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + L_CNT_ONE;
          2'b01:   r_count <= r_count - L_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      case (r_state)
        IDLE: begin
          if (w_resolveAccept) begin
            r_updAddr       <= r_addrMem[r_head];
            r_updGhr        <= r_ghrMem[r_head];
            r_updTaken      <= resolve_taken;
            r_updMispredict <= (r_predMem[r_head] != resolve_taken);
            r_state         <= UPDATE;
          end
        end
        UPDATE: begin
          if (upd_ready) begin
            r_head <= r_head + L_PTR_ONE;
            if (r_totalCount != '1) r_totalCount <= r_totalCount + L_ACC_ONE;
            if (!r_updMispredict && (r_hitCount != '1)) r_hitCount <= r_hitCount + L_ACC_ONE;
            if (r_updMispredict) begin
              r_ghrRestoreValid <= 1'b1;
              r_ghrRestoreValue <= {r_updGhr[GHR_W-2:0], r_updTaken};
              r_state           <= RECOVER;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        RECOVER: begin
          r_tail  <= r_head;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
